// File: rtl/irq_prio_ctrl_pkg.sv
// Shared types and sizing for the priority interrupt controller.
// Pure definitions: no logic, no latency.
// No flow control of its own.
package irq_prio_ctrl_pkg;

    localparam int N_SRC   = 16;
    localparam int PRIO_W  = 2;
    localparam int ID_W    = 4;
    localparam int TMO_CYC = 64;
    localparam int TMO_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SRV  = 2'd2
    } state_t;

endpackage

// File: rtl/irq_prio_ctrl_if.sv
// Request/priority inputs and CPU handshake outputs of the interrupt controller.
// Wires only, zero latency.
// The CPU paces the handshake with ack/eoi pulses; there is no other backpressure.
interface irq_prio_ctrl_if;
    import irq_prio_ctrl_pkg::*;

    logic                    m_en;
    logic [N_SRC-1:0]        req;
    logic [N_SRC*PRIO_W-1:0] prio;
    logic [N_SRC-1:0]        mask;
    logic                    ack;
    logic                    eoi;
    logic                    irq;
    logic [ID_W-1:0]         id;
    logic [PRIO_W-1:0]       level;
    logic                    busy;
    logic                    tmo;

    modport master (
        output m_en, req, prio, mask, ack, eoi,
        input  irq, id, level, busy, tmo
    );

    modport slave (
        input  m_en, req, prio, mask, ack, eoi,
        output irq, id, level, busy, tmo
    );

endinterface

// File: rtl/irq_prio_resolve.sv
// Picks the most urgent eligible source; equal priorities go to the lowest index.
// Purely combinational, zero latency.
// No flow control.
module irq_prio_resolve
    import irq_prio_ctrl_pkg::*;
(
    input  logic [N_SRC-1:0]        eligible,
    input  logic [N_SRC*PRIO_W-1:0] prio,
    output logic [ID_W-1:0]         win_id,
    output logic [PRIO_W-1:0]       win_level,
    output logic                    any_valid
);

    // Ascending scan with a strict compare keeps the lowest index on a tie.
    always_comb begin
        win_id    = '0;
        win_level = '0;
        any_valid = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (eligible[i] && (!any_valid || (prio[PRIO_W*i +: PRIO_W] > win_level))) begin
                any_valid = 1'b1;
                win_id    = ID_W'(i);
                win_level = prio[PRIO_W*i +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/irq_prio_ctrl.sv
// Edge-detected, priority-arbitrated interrupt controller with irq/ack/eoi handshake.
// Latency: request edge registered at edge k, irq asserted after edge k+1.
// Backpressure: REQ waits for ack (or times out with IRQ_PRIO_CTRL_TIMEOUT_EN); SRV waits for eoi.
module irq_prio_ctrl
    import irq_prio_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    irq_prio_ctrl_if.slave bus
);

    state_t            state, state_nxt;
    logic [N_SRC-1:0]  pending, req_q, eligible, clr;
    logic [ID_W-1:0]   id_q, id_nxt, win_id;
    logic [PRIO_W-1:0] level_q, level_nxt, win_level;
    logic              any_valid;
    logic              tmo_q, tmo_nxt;
    logic              tmo_hit;

    assign eligible = pending & bus.mask & {N_SRC{bus.m_en}};

    irq_prio_resolve u_resolve (
        .eligible  (eligible),
        .prio      (bus.prio),
        .win_id    (win_id),
        .win_level (win_level),
        .any_valid (any_valid)
    );

`ifdef IRQ_PRIO_CTRL_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counts cycles spent in REQ; any exit from REQ restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if ((state == REQ) && (state_nxt == REQ)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (state == REQ) && (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        id_nxt    = id_q;
        level_nxt = level_q;
        clr       = '0;
        tmo_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nxt = REQ;
                    id_nxt    = win_id;
                    level_nxt = win_level;
                end
            end
            REQ: begin
                // ack outranks both loss of eligibility and the timeout.
                if (bus.ack) begin
                    clr       = N_SRC'(1) << id_q;
                    state_nxt = SRV;
                end else if (!any_valid) begin
                    state_nxt = IDLE;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                    tmo_nxt   = 1'b1;
                end else begin
                    id_nxt    = win_id;
                    level_nxt = win_level;
                end
            end
            SRV: begin
                if (bus.eoi) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            req_q   <= '0;
            pending <= '0;
            id_q    <= '0;
            level_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            req_q   <= bus.req;
            // A new edge on the source being acked wins over the clear.
            pending <= (pending & ~clr) | (bus.req & ~req_q);
            id_q    <= id_nxt;
            level_q <= level_nxt;
            tmo_q   <= tmo_nxt;
        end
    end

    assign bus.irq   = (state == REQ);
    assign bus.busy  = (state == SRV);
    assign bus.id    = id_q;
    assign bus.level = level_q;
    assign bus.tmo   = tmo_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Bench for irq_prio_ctrl: a per-cycle reference model plus directed scenarios with literal expectations.
module tb_irq_prio_ctrl;
    import irq_prio_ctrl_pkg::*;

`ifdef IRQ_PRIO_CTRL_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    irq_prio_ctrl_if bus ();

    irq_prio_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: st 0=idle, 1=requesting, 2=in service; inreq counts cycles spent requesting.
    typedef struct {
        bit [15:0] pend;
        bit [15:0] reqq;
        int        st;
        int        id;
        int        lvl;
        int        inreq;
        bit        tmo;
    } mdl_t;

    mdl_t m;

    function automatic int prio_of(int i);
        return int'(bus.prio[2*i +: 2]);
    endfunction

    function automatic mdl_t step(mdl_t s);
        mdl_t      n = s;
        bit [15:0] el;
        bit [15:0] edges;
        int        w = -1;
        int        wl = 0;
        edges  = bus.req & ~s.reqq;
        n.reqq = bus.req;
        el     = s.pend & bus.mask & {16{bus.m_en}};
        // Search from most urgent level down, lowest index first within a level.
        for (int l = 3; l >= 0; l--) begin
            for (int i = 0; i < 16; i++) begin
                if (w < 0 && el[i] && prio_of(i) == l) begin
                    w  = i;
                    wl = l;
                end
            end
        end
        n.tmo = 1'b0;
        case (s.st)
            0: if (w >= 0) begin
                n.st = 1; n.id = w; n.lvl = wl; n.inreq = 1;
            end
            1: if (bus.ack) begin
                n.pend[s.id] = 1'b0;
                n.st = 2;
            end else if (w < 0) begin
                n.st = 0;
            end else if (TMO_ON && s.inreq == TMO_CYC) begin
                n.st = 0;
                n.tmo = 1'b1;
            end else begin
                n.id = w; n.lvl = wl; n.inreq = s.inreq + 1;
            end
            2: if (bus.eoi) n.st = 0;
            default: n.st = 0;
        endcase
        n.pend = n.pend | edges;
        return n;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.pend = '0; r.reqq = '0; r.st = 0; r.id = 0; r.lvl = 0; r.inreq = 0; r.tmo = 1'b0;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= mdl_reset();
        else        m <= step(m);
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if (bus.irq !== (m.st == 1) || bus.busy !== (m.st == 2) || bus.id !== 4'(m.id) ||
                bus.level !== 2'(m.lvl) || bus.tmo !== m.tmo) begin
                failures++;
                $display("FAIL model_cycle t=%0t got irq=%b busy=%b id=%0d level=%0d tmo=%b want irq=%b busy=%b id=%0d level=%0d tmo=%b",
                         $time, bus.irq, bus.busy, bus.id, bus.level, bus.tmo,
                         (m.st == 1), (m.st == 2), m.id, m.lvl, m.tmo);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic ack_eoi();
        bus.ack = 1'b1; tick(1); bus.ack = 1'b0;
        bus.eoi = 1'b1; tick(1); bus.eoi = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.m_en = 1'b0; bus.req = '0; bus.prio = '0; bus.mask = '0;
        bus.ack = 1'b0; bus.eoi = 1'b0;
        tick(3);
        chk("rst_irq", int'(bus.irq), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_id", int'(bus.id), 0);
        chk("rst_tmo", int'(bus.tmo), 0);
        rst_n = 1'b1;
        tick(3);
        chk("idle_after_rst", int'(bus.irq), 0);

        // Single source, latency and handshake.
        bus.m_en = 1'b1; bus.mask = 16'hFFFF; bus.prio = 32'h0;
        bus.req = 16'h0020;
        tick(1); chk("lat_not_yet", int'(bus.irq), 0);
        tick(1); chk("single_irq", int'(bus.irq), 1);
        chk("single_id", int'(bus.id), 5);
        chk("single_level", int'(bus.level), 0);
        bus.ack = 1'b1; tick(1); bus.ack = 1'b0;
        chk("single_srv_irq", int'(bus.irq), 0);
        chk("single_srv_busy", int'(bus.busy), 1);
        bus.eoi = 1'b1; tick(1); bus.eoi = 1'b0;
        chk("single_eoi_busy", int'(bus.busy), 0);
        bus.req = '0;
        bus.ack = 1'b1; bus.eoi = 1'b1; tick(1); bus.ack = 1'b0; bus.eoi = 1'b0;
        chk("stray_ack_eoi_busy", int'(bus.busy), 0);
        chk("stray_ack_eoi_irq", int'(bus.irq), 0);

        // Priority and tie-break.
        bus.mask = 16'h02C0; bus.prio = 32'h80CE00C0; bus.req = 16'h02C0;
        tick(2);
        chk("prio_id", int'(bus.id), 9);
        chk("prio_level", int'(bus.level), 3);
        ack_eoi(); tick(1);
        chk("tie_id", int'(bus.id), 6);
        chk("tie_level", int'(bus.level), 0);
        ack_eoi(); tick(1);
        chk("third_id", int'(bus.id), 7);
        bus.ack = 1'b1; bus.eoi = 1'b1; tick(1); bus.ack = 1'b0; bus.eoi = 1'b0;
        chk("ack_eoi_same_busy", int'(bus.busy), 1);
        bus.eoi = 1'b1; tick(1); bus.eoi = 1'b0;
        bus.req = '0;

        // Master enable gating.
        bus.mask = 16'hFFFF; bus.prio = 32'h0; bus.m_en = 1'b0; bus.req = 16'h0008;
        tick(10); chk("men_off_irq", int'(bus.irq), 0);
        bus.m_en = 1'b1; tick(1);
        chk("men_on_irq", int'(bus.irq), 1);
        chk("men_on_id", int'(bus.id), 3);
        ack_eoi(); bus.req = '0;

        // Re-arbitration before ack.
        bus.prio = 32'h0030_0010; bus.req = 16'h0004;
        tick(2); chk("rearb_first_id", int'(bus.id), 2);
        chk("rearb_first_level", int'(bus.level), 1);
        bus.req = 16'h0404;
        tick(2); chk("rearb_new_id", int'(bus.id), 10);
        chk("rearb_new_level", int'(bus.level), 3);
        ack_eoi(); tick(1);
        chk("rearb_left_irq", int'(bus.irq), 1);
        chk("rearb_left_id", int'(bus.id), 2);
        ack_eoi(); bus.req = '0;

        // Edge on the source being acked is recorded again.
        bus.prio = 32'h0; bus.req = 16'h0020; tick(1); bus.req = '0; tick(1);
        chk("setwin_irq", int'(bus.irq), 1);
        bus.ack = 1'b1; bus.req = 16'h0020; tick(1); bus.ack = 1'b0; bus.req = '0;
        bus.eoi = 1'b1; tick(1); bus.eoi = 1'b0; tick(1);
        chk("setwin_again_irq", int'(bus.irq), 1);
        chk("setwin_again_id", int'(bus.id), 5);
        ack_eoi();

        // Eligibility lost while requesting.
        bus.req = 16'h0001; tick(2); chk("drop_irq_on", int'(bus.irq), 1);
        bus.mask = 16'h0; tick(1); chk("drop_irq_off", int'(bus.irq), 0);
        bus.mask = 16'hFFFF; tick(1); chk("drop_irq_back", int'(bus.irq), 1);
        ack_eoi(); bus.req = '0;

`ifdef IRQ_PRIO_CTRL_TIMEOUT_EN
        bus.req = 16'h0100; tick(2); chk("tmo_irq_start", int'(bus.irq), 1);
        tick(63); chk("tmo_still_req", int'(bus.irq), 1);
        tick(1); chk("tmo_pulse", int'(bus.tmo), 1);
        chk("tmo_irq_low", int'(bus.irq), 0);
        tick(1); chk("tmo_reassert", int'(bus.irq), 1);
        chk("tmo_same_id", int'(bus.id), 8);
        ack_eoi(); bus.req = '0;
`else
        bus.req = 16'h0100; tick(2);
        tick(70); chk("notmo_still_req", int'(bus.irq), 1);
        chk("notmo_tmo_low", int'(bus.tmo), 0);
        ack_eoi(); bus.req = '0;
`endif

        // Reset mid-request, then a line held through release.
        bus.req = 16'h0012; tick(2); chk("mid_rst_pre_irq", int'(bus.irq), 1);
        rst_n = 1'b0; #1;
        chk("mid_rst_irq", int'(bus.irq), 0);
        chk("mid_rst_id", int'(bus.id), 0);
        chk("mid_rst_level", int'(bus.level), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        bus.req = 16'h0010;
        tick(2); rst_n = 1'b1;
        tick(2);
        chk("held_edge_irq", int'(bus.irq), 1);
        chk("held_edge_id", int'(bus.id), 4);
        ack_eoi(); tick(2);
        chk("pending_discarded", int'(bus.irq), 0);
        bus.req = '0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_prio_ctrl.md
Name: irq_prio_ctrl

Overview:
- Sequential interrupt controller around the 16-source, 2-bit-priority resolution datapath (master enable, 32-bit priority vector, 16-bit mask).
- Edge-detects requests into a pending register and arbitrates eligible sources by priority.
- Runs an irq/ack/eoi handshake with the CPU and tracks the one in-service source.

Parameters:
N_SRC, 16, number of interrupt sources
PRIO_W, 2, priority field width per source (higher value = more urgent)
ID_W, 4, source index width, equals clog2(N_SRC)
TMO_CYC, 64, ack timeout in cycles (used only with the optional feature)

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
m_en  in  1  master enable; 0 blocks new irq assertion
req  in  N_SRC  request lines, synchronous to clk
prio  in  N_SRC*PRIO_W  priority of source i in prio[PRIO_W*i +: PRIO_W]
mask  in  N_SRC  1 = source enabled
ack  in  1  CPU acknowledge, 1-cycle pulse
eoi  in  1  end-of-interrupt, 1-cycle pulse
irq  out  1  interrupt request to CPU
id  out  ID_W  winning / in-service source index
level  out  PRIO_W  priority of id
busy  out  1  a source is in service
tmo  out  1  ack-timeout pulse; constant 0 without the macro

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: pending=0, req_q=0, state=IDLE, irq=0, id=0, level=0, busy=0, tmo=0, timeout counter=0.
- Reset mid-operation aborts the handshake and discards all pending events.
- Edge detect: req_q <= req. pending[i] is set on req[i] & ~req_q[i]. A line held high through reset release counts as an edge.
- Pending sets regardless of mask and m_en.
- Eligibility: eligible = pending & mask & {N_SRC{m_en}}.
- Winner: the eligible source with the maximum priority. On a tie, the lowest index wins.
- IDLE: irq=0, busy=0. Any eligible source -> REQ at the next edge, loading id/level from the winner.
- Latency: an edge sampled at clock edge k gives irq=1 after edge k+1.
- REQ: irq=1. id/level re-evaluate every cycle, so a higher-priority arrival replaces the winner before ack.
- REQ + ack: clear pending[id] and go to SRV.
- REQ with no eligible source left (mask or m_en dropped): return to IDLE, irq=0.
- SRV: irq=0, busy=1. id/level hold the serviced source. eoi -> IDLE.
- New edges accumulate during SRV, including on the in-service source.
- ack outside REQ is ignored. eoi outside SRV is ignored.
- Simultaneous new edge and ack-clear on the same source: the set wins, so the event is recorded again.
- ack and eoi in the same cycle while in REQ: the ack is taken and the eoi is ignored.
- No nesting: at most one source is in service.

Optional Feature:
IRQ_PRIO_CTRL_TIMEOUT_EN
- With the macro:
  - An 8-bit counter runs while in REQ and clears on leaving REQ.
  - If it reaches TMO_CYC-1 without ack: tmo pulses for 1 cycle, state returns to IDLE and pending is retained.
  - Re-arbitration then proceeds normally, re-asserting irq one cycle later.
- Without the macro: no counter, tmo tied to 0, and REQ waits for ack indefinitely.

Decomposition:
- Package irq_prio_ctrl_pkg holds:
  - the state enum (IDLE, REQ, SRV);
  - N_SRC, PRIO_W, ID_W defaults;
  - the TMO_CYC default.
- Sub-module irq_prio_resolve: purely combinational. Takes eligible and prio, outputs winner id, level and any_valid. Tie-break is the lowest index.
- The top level holds pending, the edge detect, the FSM and the optional counter.

Test Plan:
1. Reset: rst_n=0 mid-REQ -> irq=0, id=0, level=0, busy=0 immediately. Release with req=0 -> stays IDLE.
2. Single source: m_en=1, mask=16'hFFFF, prio=0, req[5] rises at edge k -> irq=1 after edge k+1 with id=5, level=0. ack -> irq=0, busy=1. eoi -> busy=0.
3. Priority and tie: mask=16'h02C0, prio=32'h80CE00C0, req[6], req[7], req[9] rise together -> id=9, level=3. After ack/eoi -> id=6, level=0 (tie resolved to lowest index). Then id=7.
4. Master enable: m_en=0, req[3] edge -> irq stays 0 for 10 cycles, pending[3]=1. m_en=1 -> irq=1 one cycle later with id=3.
5. Re-arbitration: irq=1 with id=2 (prio 1). req[10] (prio 3) rises before ack -> id=10 next cycle. ack -> pending[10] cleared, pending[2] still 1; after eoi, id=2 is served.
6. Timeout (macro defined, TMO_CYC=64): irq=1, no ack for 64 cycles -> tmo pulse, irq=0 for one cycle, then irq=1 with the same id.
